// File: rtl/i2s_rx_ctrl.sv
// i2s_rx_ctrl: I2S receive master for the Hazard2 audio front end.
// Divides HCLK into sck/ws, deserialises Philips-format (one-bit delay)
// stereo frames from sd and queues each frame as a 64-bit word for a
// ready/valid consumer. Frames arriving while the queue is full are dropped
// and flagged with a sticky overrun bit.
module i2s_rx_ctrl #(
  parameter int CLK_DIV_W  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 en,
  input  logic [CLK_DIV_W-1:0] clk_div,
  input  logic                 sd,
  output logic                 sck,
  output logic                 ws,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic [63:0]          sample_data,
  output logic [LVL_W-1:0]     fifo_level,
  output logic                 overrun,
  input  logic                 clr_overrun,
  output logic                 busy
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Bus word layout: each 24-bit channel sits in the low bits of a 32-bit lane.
  function automatic logic [63:0] pack_frame(input logic [23:0] left, input logic [23:0] right);
    return {8'h00, left, 8'h00, right};
  endfunction

  // Clock generation / sequencing state
  state_t               state_r;
  logic [CLK_DIV_W-1:0] div_r;
  logic [CLK_DIV_W-1:0] div_cnt_r;
  logic                 sck_r;
  logic                 ws_r;
  logic                 busy_r;
  logic [5:0]           bit_cnt_r;

  // Capture shift registers
  logic [23:0]          left_r;
  logic [23:0]          right_r;

  // Frame FIFO
  logic [63:0]          mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [LVL_W-1:0]     level_r;
  logic                 sample_valid_r;
  logic [63:0]          sample_data_r;
  logic                 overrun_r;

  // Combinational decode
  logic                 tick_s;
  logic                 rise_s;
  logic                 fall_s;
  logic                 wrap_s;
  logic                 capture_s;
  logic [4:0]           slot_s;
  logic [5:0]           bit_cnt_inc_s;
  logic [63:0]          frame_s;
  logic                 full_s;
  logic                 push_s;
  logic                 drop_s;
  logic                 pop_s;
  logic [LVL_W-1:0]     level_nxt_s;
  logic [PTR_W-1:0]     rd_ptr_nxt_s;
  logic [63:0]          head_nxt_s;

  // Turn the divider terminal count into sck edge strobes and the capture slot.
  always_comb begin
    tick_s        = (state_r != ST_IDLE) && (div_cnt_r == div_r);
    rise_s        = tick_s && !sck_r;
    fall_s        = tick_s && sck_r;
    bit_cnt_inc_s = bit_cnt_r + 6'd1;
    wrap_s        = fall_s && (bit_cnt_r == 6'd63);
    slot_s        = bit_cnt_r[4:0];
    // Slot 0 carries the previous word's LSB position (one-bit delay); slots
    // past 24 are padding from 32-bit-slot codecs.
    capture_s     = rise_s && (slot_s >= 5'd1) && (slot_s <= 5'd24);
    frame_s       = pack_frame(left_r, right_r);
  end

  // FIFO push/pop decisions and the next head word presented to the consumer.
  always_comb begin
    full_s = (level_r == FULL_LVL);
    // A pop in the same cycle does not make room for a push into a full FIFO.
    push_s = wrap_s && !full_s;
    drop_s = wrap_s && full_s;
    pop_s  = sample_valid_r && sample_ready;

    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1'b1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1'b1);
      default: level_nxt_s = level_r;
    endcase

    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1'b1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    // The new head may be the word being written this very cycle.
    if (level_nxt_s == {LVL_W{1'b0}}) begin
      head_nxt_s = 64'h0;
    end else if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      head_nxt_s = frame_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Sequencer: IDLE/RUN/DRAIN with the sck/ws generator and bit counter.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r   <= ST_IDLE;
      div_r     <= {CLK_DIV_W{1'b0}};
      div_cnt_r <= {CLK_DIV_W{1'b0}};
      sck_r     <= 1'b0;
      ws_r      <= 1'b0;
      bit_cnt_r <= 6'd0;
      busy_r    <= 1'b0;
    end else begin
      // busy trails the state by one edge so it drops on the edge after the
      // final push.
      busy_r <= (state_r != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          div_cnt_r <= {CLK_DIV_W{1'b0}};
          sck_r     <= 1'b0;
          ws_r      <= 1'b0;
          bit_cnt_r <= 6'd0;
          if (en) begin
            // The divider is frozen for the whole run; later clk_div writes
            // wait for the next start.
            div_r   <= clk_div;
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (tick_s) begin
            div_cnt_r <= {CLK_DIV_W{1'b0}};
            sck_r     <= !sck_r;
          end else begin
            div_cnt_r <= div_cnt_r + CLK_DIV_W'(1'b1);
          end
          if (fall_s) begin
            bit_cnt_r <= bit_cnt_inc_s;
            ws_r      <= bit_cnt_inc_s[5];
          end
          // Re-enabling during DRAIN resumes seamlessly; otherwise stop only
          // on a frame boundary, where sck has just fallen and ws is left.
          if ((state_r == ST_DRAIN) && wrap_s && !en) begin
            state_r <= ST_IDLE;
          end else if (en) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          div_cnt_r <= {CLK_DIV_W{1'b0}};
          sck_r     <= 1'b0;
          ws_r      <= 1'b0;
          bit_cnt_r <= 6'd0;
        end
      endcase
    end
  end

  // Shift sd MSB-first into the channel selected by the current half-frame.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      left_r  <= 24'h0;
      right_r <= 24'h0;
    end else if (capture_s) begin
      if (!bit_cnt_r[5]) begin
        left_r <= {left_r[22:0], sd};
      end else begin
        right_r <= {right_r[22:0], sd};
      end
    end
  end

  // Frame storage: write the completed frame at the tail.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 64'h0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= frame_s;
    end
  end

  // FIFO pointers, occupancy and the registered head/valid outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_r       <= {PTR_W{1'b0}};
      rd_ptr_r       <= {PTR_W{1'b0}};
      level_r        <= {LVL_W{1'b0}};
      sample_valid_r <= 1'b0;
      sample_data_r  <= 64'h0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      rd_ptr_r       <= rd_ptr_nxt_s;
      level_r        <= level_nxt_s;
      sample_valid_r <= (level_nxt_s != {LVL_W{1'b0}});
      sample_data_r  <= head_nxt_s;
    end
  end

  // Sticky overrun flag; clearing wins over a simultaneous drop.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      overrun_r <= 1'b0;
    end else if (clr_overrun) begin
      overrun_r <= 1'b0;
    end else if (drop_s) begin
      overrun_r <= 1'b1;
    end
  end

  assign sck          = sck_r;
  assign ws           = ws_r;
  assign busy         = busy_r;
  assign sample_valid = sample_valid_r;
  assign sample_data  = sample_data_r;
  assign fifo_level   = level_r;
  assign overrun      = overrun_r;

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// tb_i2s_rx_ctrl: drives i2s_rx_ctrl with a behavioural codec on sd and checks
// clock waveforms, frame words, FIFO occupancy and overrun against a model
// derived from frame timing (64 sck periods of 2*(clk_div+1) HCLK each).
module tb_i2s_rx_ctrl;

  logic        HCLK         = 1'b0;
  logic        HRESETn      = 1'b0;
  logic        en           = 1'b0;
  logic [7:0]  clk_div      = 8'd0;
  logic        sd           = 1'b0;
  logic        sample_ready = 1'b0;
  logic        clr_overrun  = 1'b0;
  logic        sck;
  logic        ws;
  logic        sample_valid;
  logic [63:0] sample_data;
  logic [2:0]  fifo_level;
  logic        overrun;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-frame channel words played by the codec model, indexed by frame number.
  logic [23:0] fl [0:15];
  logic [23:0] fr [0:15];
  int codec_f = 0;
  int codec_k = 0;

  always #5 HCLK = ~HCLK;

  i2s_rx_ctrl dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .en           (en),
    .clk_div      (clk_div),
    .sd           (sd),
    .sck          (sck),
    .ws           (ws),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_data  (sample_data),
    .fifo_level   (fifo_level),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun),
    .busy         (busy)
  );

  // Bit k (0..63) of frame f on the wire: Philips format, MSB one sck after ws changes.
  function automatic logic codec_bit(input int f, input int k);
    logic [23:0] w;
    logic [31:0] r;
    int s;
    s = k % 32;
    w = (k < 32) ? fl[f % 16] : fr[f % 16];
    r = $urandom;
    if (s >= 1 && s <= 24) return w[24 - s];
    return r[0];
  endfunction

  function automatic logic [63:0] exp_word(input int f);
    return {8'h00, fl[f % 16], 8'h00, fr[f % 16]};
  endfunction

  task automatic codec_start(input int f);
    codec_f = f;
    codec_k = 0;
    sd = codec_bit(f, 0);
  endtask

  // Codec slave: shifts the next bit out on every falling sck.
  always @(negedge sck) begin
    if (HRESETn) begin
      if (codec_k == 63) begin
        codec_k = 0;
        codec_f = codec_f + 1;
      end else begin
        codec_k = codec_k + 1;
      end
      sd = codec_bit(codec_f, codec_k);
    end
  end

  // Start a run; returns just after the edge that leaves IDLE (edge 0).
  task automatic start_run(input int d, input int f);
    @(negedge HCLK);
    clk_div = 8'(d);
    codec_start(f);
    en = 1'b1;
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    n_cmp++;
    if ({sck, ws, sample_valid, sample_data, fifo_level, overrun, busy} !== 72'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got sck=%b ws=%b val=%b dat=%h lvl=%0d ovr=%b busy=%b exp all 0",
               sck, ws, sample_valid, sample_data, fifo_level, overrun, busy);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    n_cmp++;
    if ({sck, ws, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL idle_after_reset got sck=%b ws=%b busy=%b exp 0 0 0", sck, ws, busy);
    end
  endtask

  task automatic test_single_frame();
    logic e_sck, e_ws;
    fl[0] = 24'h667788;
    fr[0] = 24'hCDEFAB;
    start_run(1, 0);
    for (int i = 1; i <= 260; i++) begin
      @(posedge HCLK);
      #1;
      if (i == 200) en = 1'b0;
      e_sck = (i <= 256) ? 1'((i / 2) % 2) : 1'b0;
      e_ws  = (i <= 256) ? (((i / 4) % 64) >= 32) : 1'b0;
      n_cmp++;
      if ({sck, ws} !== {e_sck, e_ws}) begin
        n_bad++;
        $display("FAIL single_wave cyc %0d got sck=%b ws=%b exp sck=%b ws=%b", i, sck, ws, e_sck, e_ws);
      end
      if (i == 255) begin
        n_cmp++;
        if ({sample_valid, fifo_level} !== {1'b0, 3'd0}) begin
          n_bad++;
          $display("FAIL single_prepush got val=%b lvl=%0d exp 0 0", sample_valid, fifo_level);
        end
      end
      if (i == 256) begin
        n_cmp++;
        if ({sample_valid, fifo_level, sample_data, busy} !== {1'b1, 3'd1, 64'h0066778800CDEFAB, 1'b1}) begin
          n_bad++;
          $display("FAIL single_push got val=%b lvl=%0d dat=%h busy=%b exp 1 1 0066778800cdefab 1",
                   sample_valid, fifo_level, sample_data, busy);
        end
      end
      if (i == 257) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_bad++;
          $display("FAIL single_busy_fall got %b exp 0", busy);
        end
      end
    end
    @(negedge HCLK);
    sample_ready = 1'b1;
    @(posedge HCLK);
    #1;
    sample_ready = 1'b0;
    n_cmp++;
    if ({sample_valid, fifo_level, sample_data} !== {1'b0, 3'd0, 64'h0}) begin
      n_bad++;
      $display("FAIL single_pop got val=%b lvl=%0d dat=%h exp 0 0 0", sample_valid, fifo_level, sample_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] expq[$];
    logic e_val;
    fl[1] = 24'h223344; fr[1] = 24'hABABAB;
    fl[2] = 24'hBABABA; fr[2] = 24'h667788;
    expq.push_back(64'h0022334400ABABAB);
    expq.push_back(64'h00BABABA00667788);
    sample_ready = 1'b1;
    start_run(0, 1);
    for (int i = 1; i <= 262; i++) begin
      @(posedge HCLK);
      #1;
      if (i == 200) en = 1'b0;
      n_cmp++;
      if (sck !== ((i <= 256) ? 1'(i % 2) : 1'b0)) begin
        n_bad++;
        $display("FAIL b2b_sck cyc %0d got %b", i, sck);
      end
      e_val = (i == 128) || (i == 256);
      n_cmp++;
      if (sample_valid !== e_val) begin
        n_bad++;
        $display("FAIL b2b_valid cyc %0d got %b exp %b", i, sample_valid, e_val);
      end
      if (sample_valid === 1'b1 && expq.size() > 0) begin
        n_cmp++;
        if (sample_data !== expq[0]) begin
          n_bad++;
          $display("FAIL b2b_data cyc %0d got %h exp %h", i, sample_data, expq[0]);
        end
        void'(expq.pop_front());
      end
    end
    sample_ready = 1'b0;
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_count got %0d frames left exp 0", expq.size());
    end
  endtask

  task automatic test_overrun();
    logic [63:0] mq[$];
    logic        movr;
    logic [63:0] e_dat;
    int d, F;
    d = $urandom_range(2, 0);
    F = 128 * (d + 1);
    movr = 1'b0;
    for (int f = 3; f <= 7; f++) begin
      fl[f] = 24'($urandom);
      fr[f] = 24'($urandom);
    end
    start_run(d, 3);
    for (int i = 1; i <= 5 * F + 2; i++) begin
      @(posedge HCLK);
      #1;
      if (i == 4 * F + 10) en = 1'b0;
      if (i % F == 0 && i <= 5 * F) begin
        if (mq.size() == 4) movr = 1'b1;
        else mq.push_back(exp_word(3 + i / F - 1));
      end
      if (mq.size() > 0) e_dat = mq[0];
      else e_dat = 64'h0;
      n_cmp++;
      if ({fifo_level, overrun, sample_valid, sample_data} !== {3'(mq.size()), movr, (mq.size() > 0), e_dat}) begin
        n_bad++;
        $display("FAIL ovr_fill cyc %0d got lvl=%0d ovr=%b val=%b dat=%h exp lvl=%0d ovr=%b dat=%h",
                 i, fifo_level, overrun, sample_valid, sample_data, mq.size(), movr, e_dat);
      end
    end
    @(negedge HCLK);
    clr_overrun = 1'b1;
    @(posedge HCLK);
    #1;
    clr_overrun = 1'b0;
    n_cmp++;
    if ({overrun, fifo_level} !== {1'b0, 3'd4}) begin
      n_bad++;
      $display("FAIL ovr_clear got ovr=%b lvl=%0d exp 0 4", overrun, fifo_level);
    end
    @(negedge HCLK);
    sample_ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(posedge HCLK);
      #1;
      if (mq.size() > 0) void'(mq.pop_front());
      if (mq.size() > 0) e_dat = mq[0];
      else e_dat = 64'h0;
      n_cmp++;
      if ({fifo_level, sample_valid, sample_data} !== {3'(mq.size()), (mq.size() > 0), e_dat}) begin
        n_bad++;
        $display("FAIL ovr_drain pop %0d got lvl=%0d val=%b dat=%h exp lvl=%0d dat=%h",
                 j, fifo_level, sample_valid, sample_data, mq.size(), e_dat);
      end
    end
    sample_ready = 1'b0;
  endtask

  task automatic test_drain_reenable();
    logic e_sck, e_ws, e_busy;
    logic [2:0] e_lvl;
    int d, H, F;
    d = $urandom_range(3, 1);
    H = 2 * (d + 1);
    F = 64 * H;
    fl[8] = 24'($urandom); fr[8] = 24'($urandom);
    fl[9] = 24'($urandom); fr[9] = 24'($urandom);
    start_run(d, 8);
    clk_div = 8'($urandom_range(9, 5));
    for (int i = 1; i <= 2 * F + 20; i++) begin
      @(posedge HCLK);
      #1;
      if (i == 40 * H + 1) en = 1'b0;
      if (i == 50 * H + 1) en = 1'b1;
      if (i == F + 40 * H + 1) en = 1'b0;
      e_sck  = (i <= 2 * F) ? 1'((i / (d + 1)) % 2) : 1'b0;
      e_ws   = (i <= 2 * F) ? (((i / H) % 64) >= 32) : 1'b0;
      e_busy = (i <= 2 * F);
      e_lvl  = (i >= 2 * F) ? 3'd2 : ((i >= F) ? 3'd1 : 3'd0);
      n_cmp++;
      if ({sck, ws, busy, fifo_level} !== {e_sck, e_ws, e_busy, e_lvl}) begin
        n_bad++;
        $display("FAIL drain_wave cyc %0d got sck=%b ws=%b busy=%b lvl=%0d exp sck=%b ws=%b busy=%b lvl=%0d",
                 i, sck, ws, busy, fifo_level, e_sck, e_ws, e_busy, e_lvl);
      end
    end
  endtask

  task automatic test_push_pop();
    logic [63:0] mq[$];
    logic [63:0] e_dat;
    int d, F;
    d = $urandom_range(2, 0);
    F = 128 * (d + 1);
    fl[10] = 24'($urandom);
    fr[10] = 24'($urandom);
    mq.push_back(exp_word(8));
    mq.push_back(exp_word(9));
    start_run(d, 10);
    for (int i = 1; i <= F + 3; i++) begin
      @(posedge HCLK);
      #1;
      if (i == F / 2) en = 1'b0;
      if (i == F) begin
        sample_ready = 1'b0;
        void'(mq.pop_front());
        mq.push_back(exp_word(10));
      end
      if (i == F - 1) sample_ready = 1'b1;
      e_dat = mq[0];
      n_cmp++;
      if ({fifo_level, sample_valid, sample_data} !== {3'(mq.size()), 1'b1, e_dat}) begin
        n_bad++;
        $display("FAIL pushpop cyc %0d got lvl=%0d val=%b dat=%h exp lvl=%0d dat=%h",
                 i, fifo_level, sample_valid, sample_data, mq.size(), e_dat);
      end
    end
    @(negedge HCLK);
    sample_ready = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      @(posedge HCLK);
      #1;
      if (mq.size() > 0) void'(mq.pop_front());
      if (mq.size() > 0) e_dat = mq[0];
      else e_dat = 64'h0;
      n_cmp++;
      if ({fifo_level, sample_data} !== {3'(mq.size()), e_dat}) begin
        n_bad++;
        $display("FAIL pushpop_drain pop %0d got lvl=%0d dat=%h exp lvl=%0d dat=%h",
                 j, fifo_level, sample_data, mq.size(), e_dat);
      end
    end
    sample_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int d, H, F;
    d = $urandom_range(2, 0);
    H = 2 * (d + 1);
    F = 64 * H;
    for (int f = 11; f <= 14; f++) begin
      fl[f] = 24'($urandom);
      fr[f] = 24'($urandom);
    end
    start_run(d, 11);
    for (int i = 1; i <= 2 * F + 20 * H; i++) begin
      @(posedge HCLK);
      #1;
      if (i == 2 * F) begin
        n_cmp++;
        if (fifo_level !== 3'd2) begin
          n_bad++;
          $display("FAIL rstmid_level got %0d exp 2", fifo_level);
        end
      end
    end
    #3;
    HRESETn = 1'b0;
    #1;
    n_cmp++;
    if ({sck, ws, sample_valid, sample_data, fifo_level, overrun, busy} !== 72'h0) begin
      n_bad++;
      $display("FAIL rstmid_outputs got sck=%b ws=%b val=%b dat=%h lvl=%0d ovr=%b busy=%b exp all 0",
               sck, ws, sample_valid, sample_data, fifo_level, overrun, busy);
    end
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    codec_start(14);
    @(posedge HCLK);
    #1;
    for (int i = 1; i <= F + 2; i++) begin
      @(posedge HCLK);
      #1;
      if (i == F / 2) en = 1'b0;
      if (i == F) begin
        n_cmp++;
        if ({fifo_level, sample_valid, sample_data} !== {3'd1, 1'b1, exp_word(14)}) begin
          n_bad++;
          $display("FAIL rstmid_frame got lvl=%0d val=%b dat=%h exp lvl=1 dat=%h",
                   fifo_level, sample_valid, sample_data, exp_word(14));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_drain_reenable();
    test_push_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
